// File: rtl/matrix_pkg.sv
// Shared widths, beat counts and FSM state encoding for the 2x2 matrix multiplier.
package matrix_pkg;
  localparam int ELEM_W = 2;
  localparam int RES_W  = 5;
  localparam int N_IN   = 8;
  localparam int N_OUT  = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    SEND    = 2'd2
  } state_t;
endpackage

// File: rtl/matrix_dot2.sv
// Two-term unsigned dot product x0*y0 + x1*y1 at full result precision.
module matrix_dot2
  import matrix_pkg::*;
(
  input  logic [ELEM_W-1:0] x0,
  input  logic [ELEM_W-1:0] y0,
  input  logic [ELEM_W-1:0] x1,
  input  logic [ELEM_W-1:0] y1,
  output logic [RES_W-1:0]  dot
);
  assign dot = RES_W'(x0) * RES_W'(y0) + RES_W'(x1) * RES_W'(y1);
endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential 2x2 matrix multiplier: streams in A then B, computes one C element
// per cycle through a single shared dot-product unit, then streams C out.
module matrix_mul_seq
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [RES_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);
  state_t state, state_nxt;
  logic [2:0] cnt;
  logic       armed;
  logic [N_OUT-1:0][ELEM_W-1:0] a_mat, b_mat;
  logic [N_OUT-1:0][RES_W-1:0]  c_mat;
  logic [RES_W-1:0] dot;

  // cnt[1] selects the row of A, cnt[0] the column of B.
  matrix_dot2 u_dot (
    .x0  (a_mat[{cnt[1], 1'b0}]),
    .y0  (b_mat[{1'b0, cnt[0]}]),
    .x1  (a_mat[{cnt[1], 1'b1}]),
    .y1  (b_mat[{1'b1, cnt[0]}]),
    .dot (dot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = armed;
        if (in_valid && armed && cnt == 3'(N_IN - 1)) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (cnt == 3'(N_OUT - 1)) state_nxt = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && cnt == 3'(N_OUT - 1)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign out_last = out_valid && (cnt == 3'(N_OUT - 1));
  assign out_data = out_valid ? c_mat[cnt[1:0]] : '0;

  // armed holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cnt   <= '0;
      a_mat <= '0;
      b_mat <= '0;
      c_mat <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        LOAD: if (in_valid && armed) begin
          if (!cnt[2]) a_mat[cnt[1:0]] <= in_data;
          else         b_mat[cnt[1:0]] <= in_data;
          cnt <= cnt + 3'd1;
        end
        COMPUTE: begin
          c_mat[cnt[1:0]] <= dot;
          cnt <= (cnt == 3'(N_OUT - 1)) ? 3'd0 : cnt + 3'd1;
        end
        SEND: if (out_ready)
          cnt <= (cnt == 3'(N_OUT - 1)) ? 3'd0 : cnt + 3'd1;
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: doc/matrix_mul_seq.md
MATRIX_MUL_SEQ -- requirements
Module: matrix_mul_seq

Interface
REQ-001 Ports SHALL be exactly the following (name, direction, width, meaning):
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_data holds a valid matrix element.
REQ-005 in_data  input  2  unsigned matrix element.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 out_valid  output  1  out_data holds a valid result element.
REQ-008 out_data  output  5  unsigned result element.
REQ-009 out_last  output  1  high with the final result element (c22).
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 busy  output  1  high in COMPUTE or SEND.

Function
REQ-012 The block SHALL compute C = A x B for 2x2 unsigned matrices, with 2-bit elements in and 5-bit elements out.
REQ-013 An input beat SHALL transfer on a rising edge when in_valid and in_ready are both high; an output beat SHALL transfer when out_valid and out_ready are both high.
REQ-014 Input order SHALL be a11, a12, a21, a22, b11, b12, b21, b22 (8 beats).
REQ-015 Output order SHALL be c11, c12, c21, c22 (4 beats).
REQ-016 The state machine SHALL have three states: LOAD, COMPUTE and SEND.
REQ-017 In LOAD, in_ready SHALL be 1, and a 3-bit beat counter SHALL advance 0..7 only on input handshakes.
REQ-018 After the handshake at count 7, the block SHALL go to COMPUTE on the next edge with the counter cleared.
REQ-019 COMPUTE SHALL last exactly 4 cycles and produce one element per cycle in output order: c_ij = a_i1*b_1j + a_i2*b_2j, full precision, no truncation (maximum value 18).
REQ-020 After COMPUTE, the block SHALL enter SEND; out_valid SHALL rise on the 5th cycle after the final input handshake.
REQ-021 In SEND, out_valid SHALL stay 1 until all 4 beats transfer; out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 After the handshake on c22 (out_last=1), the block SHALL return to LOAD; in_ready SHALL be 1 on the following cycle.
REQ-023 in_ready SHALL be 0 in COMPUTE and SEND; in_data and in_valid SHALL be ignored there.
REQ-024 Gaps in in_valid SHALL neither advance the counter nor corrupt stored elements.
REQ-025 out_valid and out_last SHALL be 0 outside SEND.
REQ-026 out_last SHALL be 1 only with c22.
REQ-027 out_ready SHALL be ignored outside SEND.
REQ-028 There is no abort input; a partial load SHALL be discarded only by reset.

Reset
REQ-029 While rst_n=0, state SHALL be LOAD and the counter SHALL be 0.
REQ-030 While rst_n=0: in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-031 While rst_n=0, all stored A, B and C elements SHALL be cleared to 0.
REQ-032 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-033 Reset asserted mid-LOAD, mid-COMPUTE or mid-SEND SHALL discard all data immediately; no partial result SHALL be emitted afterwards.

Structure
REQ-034 Package matrix_pkg SHALL hold ELEM_W=2, RES_W=5, the LOAD/COMPUTE/SEND state typedef, and the beat-count constants N_IN=8 and N_OUT=4.
REQ-035 One combinational sub-module, matrix_dot2 (a 2-term dot product of four ELEM_W inputs to a RES_W output), SHALL be instantiated once and time-shared across the 4 COMPUTE cycles.

Verification
REQ-036 Load A=[3 2;1 3], B=[1 1;1 1], out_ready=1 -> outputs 5,5,4,4; out_last on the 4th beat; out_valid first high 5 cycles after the last input handshake.
REQ-037 Load all elements = 3 -> outputs 18,18,18,18 (no overflow).
REQ-038 Load A=[1 0;0 1], B=[2 3;1 0], out_ready toggling 0/1 every cycle -> outputs 2,3,1,0, each held stable while stalled, exactly 4 handshakes.
REQ-039 Load with in_valid low on alternate cycles, then a second back-to-back matrix pair -> both results correct; in_ready=0 throughout COMPUTE and SEND.
REQ-040 Assert rst_n=0 after 5 input beats, then load A=[1 1;1 1], B=[1 1;1 1] -> outputs 2,2,2,2 only; no stale output.
REQ-041 Assert rst_n=0 during SEND after 2 output beats -> out_valid=0 immediately; in_ready=1 on the first edge after release.
